// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store sequencer and its lane logic.
// Byte lanes are big-endian: lane 0 is bits 31:24 of a memory word.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    function automatic logic is_store(mem_op_e op);
        return op[2] & (op != OP_LW);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(mem_op_e op, logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return |lo;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle of the load/store sequencer.
interface mem_access_unit_if
    import mem_pkg::*;
#(
    parameter int AW = 32
);
    logic          req;
    mem_op_e       op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic [31:0]   rdata;
    logic          addr_err;

    modport master (
        output req, op, addr, wdata,
        input  busy, done, rdata, addr_err
    );

    modport slave (
        input  req, op, addr, wdata,
        output busy, done, rdata, addr_err
    );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: extracts/extends a load and merges a sub-word store
// into a full memory word.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[31:24];
        case (lane)
            LANE_B0: sel_byte = word[31:24];
            LANE_B1: sel_byte = word[23:16];
            LANE_B2: sel_byte = word[15:8];
            LANE_B3: sel_byte = word[7:0];
            default: sel_byte = word[31:24];
        endcase
        sel_half = lane[1] ? word[15:0] : word[31:16];

        load_data = '0;
        case (op)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'd0, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {16'd0, sel_half};
            OP_LW:   load_data = word;
            default: load_data = '0;
        endcase
    end

    // Store merge starts from the word read back, so untouched lanes survive.
    always_comb begin
        store_data = word;
        case (op)
            OP_SB: begin
                case (lane)
                    LANE_B0: store_data[31:24] = wdata[7:0];
                    LANE_B1: store_data[23:16] = wdata[7:0];
                    LANE_B2: store_data[15:8]  = wdata[7:0];
                    LANE_B3: store_data[7:0]   = wdata[7:0];
                    default: store_data = word;
                endcase
            end
            OP_SH: begin
                if (lane[1]) store_data[15:0] = wdata[15:0];
                else         store_data[31:16] = wdata[15:0];
            end
            OP_SW:   store_data = wdata;
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the memory-stage control and a word-wide
// DATAMEM; sub-word stores go through a read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  cpu,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_data,
    output logic              mem_we,
    input  logic [DW-1:0]     mem_rdata
);

    mem_state_e    state, state_next;
    mem_op_e       op_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd_buf;
    logic [31:0]   rdata_q;
    logic          addr_err_q;
    logic          accept;
    logic [31:0]   lane_word;
    logic [31:0]   load_data;
    logic [31:0]   store_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu.req) begin
                    accept = 1'b1;
                    if (is_misaligned(cpu.op, cpu.addr[1:0])) state_next = ST_DONE;
                    else if (cpu.op == OP_SW)                 state_next = ST_WR;
                    else                                      state_next = ST_RD;
                end
            end
            ST_RD:   state_next = is_store(op_q) ? ST_WR : ST_DONE;
            ST_WR:   state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_buf     <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= cpu.op;
                addr_q     <= cpu.addr;
                wdata_q    <= cpu.wdata;
                addr_err_q <= is_misaligned(cpu.op, cpu.addr[1:0]);
            end
            if (state == ST_RD) begin
                rd_buf <= mem_rdata;
                if (!is_store(op_q)) rdata_q <= load_data;
            end
        end
    end

    // Loads extract straight from the live read; store merges use the captured word.
    assign lane_word = (state == ST_RD) ? mem_rdata : rd_buf;

    mem_lane_align u_lane_align (
        .op         (op_q),
        .lane       (addr_q[1:0]),
        .word       (lane_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign mem_addr     = {addr_q[AW-1:2], 2'b00};
    assign mem_we       = (state == ST_WR);
    assign mem_data     = (state == ST_WR) ? store_data : '0;
    assign cpu.busy     = (state != ST_IDLE);
    assign cpu.done     = (state == ST_DONE);
    assign cpu.rdata    = rdata_q;
    assign cpu.addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-array model
// of memory with big-endian lane numbering.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] dut_mem [0:15];
    logic [7:0]  ref_bytes [0:63];
    logic [31:0] ref_rdata;
    logic        ref_err;
    int          total;
    int          bad;

    mem_access_unit_if #(.AW(32)) cpu ();

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cpu),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dut_mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_we) dut_mem[mem_addr[5:2]] <= mem_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] refWord(input int a);
        int b;
        b = a - (a % 4);
        return {ref_bytes[b], ref_bytes[b+1], ref_bytes[b+2], ref_bytes[b+3]};
    endfunction

    task automatic setWord(input int a, input logic [31:0] v);
        dut_mem[a / 4] = v;
        ref_bytes[a]   = v[31:24];
        ref_bytes[a+1] = v[23:16];
        ref_bytes[a+2] = v[15:8];
        ref_bytes[a+3] = v[7:0];
    endtask

    // Drives one request, then watches it to completion and compares everything observable.
    task automatic applyStimulus(input mem_op_e o, input int a, input logic [31:0] wd);
        logic        mis;
        logic        wr;
        int          exp_lat;
        logic [31:0] exp_word;
        logic [7:0]  bv;
        logic [15:0] hv;
        int          lat;
        int          we_cnt;
        logic [31:0] we_addr;
        logic [31:0] we_data;

        mis = ((o == OP_LH || o == OP_LHU || o == OP_SH) && (a % 2 != 0)) ||
              ((o == OP_LW || o == OP_SW) && (a % 4 != 0));
        wr  = !mis && (o == OP_SB || o == OP_SH || o == OP_SW);
        exp_lat = mis ? 1 : ((o == OP_SB || o == OP_SH) ? 3 : 2);
        ref_err = mis;

        if (!mis) begin
            bv = ref_bytes[a];
            hv = {ref_bytes[a], ref_bytes[(a+1) % 64]};
            case (o)
                OP_LB:  ref_rdata = {{24{bv[7]}}, bv};
                OP_LBU: ref_rdata = {24'd0, bv};
                OP_LH:  ref_rdata = {{16{hv[15]}}, hv};
                OP_LHU: ref_rdata = {16'd0, hv};
                OP_LW:  ref_rdata = refWord(a);
                OP_SB:  ref_bytes[a] = wd[7:0];
                OP_SH:  begin ref_bytes[a] = wd[15:8]; ref_bytes[a+1] = wd[7:0]; end
                OP_SW:  begin
                    ref_bytes[a] = wd[31:24]; ref_bytes[a+1] = wd[23:16];
                    ref_bytes[a+2] = wd[15:8]; ref_bytes[a+3] = wd[7:0];
                end
                default: ;
            endcase
        end
        exp_word = refWord(a);

        @(negedge clk);
        cpu.req   = 1'b1;
        cpu.op    = o;
        cpu.addr  = a;
        cpu.wdata = wd;
        @(posedge clk);
        lat = 0; we_cnt = 0; we_addr = '0; we_data = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            cpu.req = 1'b0;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_data;
            end
            if (cpu.done) lat = c;
        end
        checkOutput($sformatf("latency op%0d a%0d", o, a), lat, exp_lat);
        checkOutput("we_count", we_cnt, wr ? 1 : 0);
        if (wr) begin
            checkOutput("we_addr", we_addr, a - (a % 4));
            checkOutput("we_data", we_data, exp_word);
        end
        checkOutput("addr_err", {31'd0, cpu.addr_err}, {31'd0, ref_err});
        checkOutput("rdata", cpu.rdata, ref_rdata);
        checkOutput("busy_at_done", {31'd0, cpu.busy}, 32'd1);
        @(negedge clk);
        checkOutput("done_pulse", {31'd0, cpu.done}, 32'd0);
        checkOutput("idle_busy", {31'd0, cpu.busy}, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, cpu.busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, cpu.done}, 32'd0);
        checkOutput({tag, "_rdata"}, cpu.rdata, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, cpu.addr_err}, 32'd0);
        checkOutput({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        checkOutput({tag, "_maddr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mdata"}, mem_data, 32'd0);
    endtask

    initial begin
        int dones;
        total = 0;
        bad = 0;
        ref_rdata = '0;
        ref_err = 1'b0;
        cpu.req = 1'b0;
        cpu.op = OP_LB;
        cpu.addr = '0;
        cpu.wdata = '0;
        for (int i = 0; i < 64; i += 4) setWord(i, 32'd0);
        setWord(4, 32'h8899AABB);
        setWord(0, 32'h11223344);

        rst_n = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_LB, 5, 32'd0);
        checkOutput("lb5", cpu.rdata, 32'hFFFFFF99);
        applyStimulus(OP_LBU, 5, 32'd0);
        checkOutput("lbu5", cpu.rdata, 32'h00000099);
        applyStimulus(OP_LH, 6, 32'd0);
        checkOutput("lh6", cpu.rdata, 32'hFFFFAABB);
        applyStimulus(OP_LHU, 4, 32'd0);
        checkOutput("lhu4", cpu.rdata, 32'h00008899);
        applyStimulus(OP_LW, 4, 32'd0);
        checkOutput("lw4", cpu.rdata, 32'h8899AABB);
        applyStimulus(OP_SB, 2, 32'h000000EE);
        applyStimulus(OP_LW, 0, 32'd0);
        checkOutput("lw0_after_sb", cpu.rdata, 32'h1122EE44);
        applyStimulus(OP_SW, 8, 32'hDEADBEEF);
        checkOutput("mem8", dut_mem[2], 32'hDEADBEEF);
        applyStimulus(OP_LW, 2, 32'd0);
        applyStimulus(OP_SH, 3, 32'h0000CAFE);

        // Reset while a halfword store is still in its read phase.
        @(negedge clk);
        cpu.req = 1'b1; cpu.op = OP_SH; cpu.addr = 32'd12; cpu.wdata = 32'h00001234;
        @(posedge clk);
        @(negedge clk);
        cpu.req = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_rd");
        ref_rdata = '0;
        ref_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset landing inside the write cycle must suppress the write.
        @(negedge clk);
        cpu.req = 1'b1; cpu.op = OP_SW; cpu.addr = 32'd16; cpu.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        cpu.req = 1'b0;
        checkOutput("wr_we_before_rst", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("wr_we_after_rst", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mem16_untouched", dut_mem[4], refWord(16));

        // A second request raised while busy must be dropped.
        @(negedge clk);
        cpu.req = 1'b1; cpu.op = OP_LW; cpu.addr = 32'd4; cpu.wdata = '0;
        @(posedge clk);
        @(negedge clk);
        cpu.addr = 32'd0;
        @(negedge clk);
        checkOutput("busy_req_done", {31'd0, cpu.done}, 32'd1);
        checkOutput("busy_req_rdata", cpu.rdata, refWord(4));
        cpu.req = 1'b0;
        ref_rdata = refWord(4);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu.done) dones++;
        end
        checkOutput("busy_req_ignored", dones, 0);

        for (int n = 0; n < 150; n++) begin
            applyStimulus(mem_op_e'($urandom_range(0, 7)), $urandom_range(0, 63), $urandom);
        end

        for (int w = 0; w < 16; w++) begin
            checkOutput($sformatf("final_mem%0d", w), dut_mem[w], refWord(w * 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the multi-cycle CPU's memory-stage control and the word-wide DATAMEM (addr, data, we, clk, data_o). Accepts one byte, halfword or word request at a time and drives DATAMEM with word-aligned addresses. Sub-word stores use read-modify-write; loads return sign- or zero-extended data. Misaligned requests are flagged and never touch memory.

Parameters:
AW, 32, byte address width of request and DATAMEM addr
DW, 32, data width (fixed 32; lane logic assumes 4 bytes)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  request strobe; sampled only in IDLE
op  in  3  access type (package encoding)
addr  in  AW  byte address
wdata  in  32  store data, right-justified for SB/SH
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result; held until next accepted request
addr_err  out  1  misalignment flag; valid with done, held until next acceptance
mem_addr  out  AW  to DATAMEM addr; always {addr[AW-1:2],2'b00}
mem_data  out  32  to DATAMEM data
mem_we  out  1  to DATAMEM we
mem_rdata  in  32  from DATAMEM data_o; combinational read of mem_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, rdata=0, addr_err=0, mem_we=0, mem_addr=0, mem_data=0, latched op/addr/wdata=0.
- Byte lanes big-endian: addr[1:0]=0 -> bits 31:24, 3 -> bits 7:0; halfword addr[1]=0 -> 31:16.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
- States: IDLE, RD, WR, DONE.
- IDLE: req=1 latches op/addr/wdata, clears addr_err. Misaligned -> DONE with addr_err=1. SW -> WR. All others -> RD. req=0 -> stay.
- RD: mem_we=0, mem_addr driven; at edge capture mem_rdata into rd_buf. Load -> DONE with rdata=extracted/extended lane. SB/SH -> WR.
- WR: mem_we=1 for exactly this cycle; mem_data = wdata (SW) or rd_buf with target lane replaced by wdata[7:0]/[15:0]. -> DONE.
- DONE: done=1; -> IDLE. req in DONE ignored (not queued).
- Latency, acceptance edge to done high: loads 2 cycles, SW 2, SB/SH 3, misaligned 1.
- req while busy ignored. mem_we never asserted for loads or misaligned requests.
- Loads sign-extend (LB/LH) or zero-extend (LBU/LHU); stores leave rdata unchanged.
- rst_n low mid-operation: immediate IDLE; a WR cycle cut by reset performs no write (mem_we drops asynchronously).

Decomposition:
- Package mem_pkg: op encoding LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7; state encoding; is_store(op)=op[2]&(op!=4) helper; lane constants.
- Sub-module mem_lane_align (combinational): load extract/extend and store merge from (op, addr[1:0], word, wdata).

Test Plan:
- Mem word 0x4 = 0x8899AABB; LB addr 0x5 -> done 2 cycles after acceptance, rdata=0xFFFFFF99; LBU addr 0x5 -> 0x00000099.
- LH addr 0x6 -> rdata=0xFFFFAABB; LHU addr 0x4 -> 0x00008899; LW addr 0x4 -> 0x8899AABB, mem_we never high.
- Word 0x0 = 0x11223344; SB addr 0x2 wdata 0x000000EE -> one mem_we pulse with mem_data 0x1122EE44, done 3 cycles after acceptance; readback LW 0x0 = 0x1122EE44.
- SW addr 0x8 wdata 0xDEADBEEF -> mem_we on next cycle, mem_addr 0x8, done after 2 cycles, no RD state.
- LW addr 0x2 and SH addr 0x3 -> done next cycle with addr_err=1, mem_we stays 0, memory unchanged.
- SH accepted, rst_n low during RD -> outputs reset values asynchronously, no write; req during busy ignored (second LW not served).
